// File: rtl/seq_mult8.sv
// Sequential unsigned 8x8 -> 16-bit shift-and-add multiplier built around a single adder8.
// Operands arrive on a valid/ready handshake; the product leaves on a valid/ready handshake 8 RUN cycles later.

module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       carry_out
);
  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | 8 shift-and-add iterations, one multiplier bit per cycle
// DONE  | product presented, held until out_ready
module seq_mult8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  mcand_q, mcand_d;
  logic [7:0]  acc_hi_q, acc_hi_d;
  logic [7:0]  acc_lo_q, acc_lo_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;

  logic [7:0]  add_b;
  logic [7:0]  add_s;
  logic        add_c;

  assign add_b = acc_lo_q[0] ? mcand_q : 8'd0;

  adder8 u_add (
    .a         (acc_hi_q),
    .b         (add_b),
    .carry_in  (1'b0),
    .sum       (add_s),
    .carry_out (add_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= 8'd0;
      acc_hi_q  <= 8'd0;
      acc_lo_q  <= 8'd0;
      cnt_q     <= 3'd0;
      product_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)        state_d = S_RUN;
      S_RUN:   if (cnt_q == 3'd7)   state_d = S_DONE;
      S_DONE:  if (out_ready)       state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = a;
          acc_hi_d = 8'd0;
          acc_lo_d = b;
          cnt_d    = 3'd0;
        end
      end
      S_RUN: begin
        // carry-out becomes the new accumulator MSB, so the 16-bit result never overflows
        {acc_hi_d, acc_lo_d} = {add_c, add_s, acc_lo_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        // separate product register keeps the result stable through DONE and after returning to IDLE
        if (cnt_q == 3'd7) product_d = {add_c, add_s, acc_lo_q[7:1]};
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    product   = product_q;
  end

endmodule

// File: doc/seq_mult8.md
Name: seq_mult8

Overview:
- Sequential unsigned 8x8 -> 16-bit shift-and-add multiplier.
- Sits directly downstream of the 8-bit adder and consumes its output: one adder8 instance is the only arithmetic datapath, used in add mode (carry_in = 0) once per cycle.
- Accepts operands over a valid/ready handshake, iterates 8 cycles, then presents the product over a valid/ready handshake.
- First multi-cycle consumer of the adder; the base for later MAC/ALU stages.

Parameters:
- None. Operand width is fixed at 8 to match adder8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  16  a*b, unsigned

Behaviour:
- Clocking and reset: one clock domain (clk); rst is asynchronous, active-high.
- While rst is high:
  - state = IDLE, out_valid = 0, product = 0, internal regs = 0.
  - in_ready = 1 (derived from state).
- Internal registers:
  - mcand[7:0]
  - acc_hi[7:0], acc_lo[7:0]; acc_lo holds remaining multiplier bits, then product low bits.
  - cnt[2:0]
  - state: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at an edge: mcand <= a, acc_hi <= 0, acc_lo <= b, cnt <= 0, state <= RUN.
- RUN (in_ready = 0, out_valid = 0):
  - adder8 inputs: acc_hi and (acc_lo[0] ? mcand : 8'd0), carry_in = 0, giving {c, s}.
  - Each edge: {acc_hi, acc_lo} <= {c, s, acc_lo[7:1]}, cnt <= cnt + 1.
  - On the edge where cnt == 7: state <= DONE.
  - Exactly 8 RUN cycles per operation.
- DONE:
  - out_valid = 1; product = {acc_hi, acc_lo}.
  - product is held stable while out_valid & !out_ready (no change under backpressure).
  - On out_ready at an edge: state <= IDLE.
  - in_ready stays 0 in DONE; no same-cycle accept/return overlap.
- Latency: accept edge E; out_valid rises after edge E+8 (visible in the cycle after the 8th RUN edge). Throughput is one product per 10 cycles minimum with out_ready tied high.
- Ignored inputs: in_valid, a and b are ignored outside IDLE. Changing a/b during RUN has no effect.
- Outputs are driven directly from registers/state; no combinational path from in_valid or out_ready to any output.
- Arithmetic: the adder carry-out is kept as the new acc_hi MSB, so the full 16-bit result is exact and there is no overflow. 255*255 = 65025.
- Reset mid-operation: rst asserted in RUN or DONE aborts immediately and returns to IDLE with out_valid = 0 and product = 0. The pending result is discarded; no partial output is produced.
- Output after return: product keeps its last value after returning to IDLE (register not cleared except by rst); out_valid = 0.

Test Plan:
- Basic: a=5, b=5, out_ready=1 -> out_valid rises exactly 9 cycles after the accept cycle; product = 16'd25.
- Extremes, back-to-back: a=255, b=255, then a=0, b=200, then a=128, b=2 -> products 16'hFE01, 16'd0, 16'd256 in order; in_ready low from accept until the cycle after each output handshake.
- Backpressure: a=11, b=13, out_ready=0 for 5 cycles after out_valid, then 1 -> product = 16'd143 stable and out_valid held for all 5 cycles; one handshake only.
- Ignored operands: in_valid=1 with a=7, b=9 held throughout RUN after accepting a=3, b=4 -> product = 16'd12; the new operands are accepted only once back in IDLE.
- Reset mid-run: accept a=100, b=100, assert rst asynchronously at RUN cycle 4 -> out_valid = 0, product = 0, in_ready = 1 immediately. A new a=2, b=3 then yields product = 16'd6.
- Carry path: a=255, b=1 -> product = 16'd255; a=255, b=2 -> product = 16'd510 (exercises adder carry into acc_hi MSB).
